// File: rtl/fft_stream_pkg.sv
// fft_stream_pkg
//   Shared types and helpers for the FFT result streamer.
//   stream_state_t : streamer FSM states (IDLE, STREAM)
//   cplx_t         : one complex bin at the default 32-bit word width,
//                    packed as {re, im}, both two's complement
//   idx_last()     : index of the final bin for a given bin count
package fft_stream_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  typedef struct packed {
    logic signed [DEF_WIDTH/2-1:0] re;
    logic signed [DEF_WIDTH/2-1:0] im;
  } cplx_t;

  // Index of the final bin in a frame of the given size.
  function automatic int idx_last(input int samples);
    return samples - 1;
  endfunction

endpackage

// File: rtl/cplx_mag_est.sv
// cplx_mag_est
//   Combinational magnitude estimate of one complex bin word:
//     mag = max(|re|,|im|) + (min(|re|,|im|) >> 1)
//   computed in WIDTH/2+1 bits so |most-negative| is exact (no saturation).
// Ports:
//   word  in  WIDTH  packed {re[WIDTH-1:WIDTH/2], im[WIDTH/2-1:0]}
//   mag   out WIDTH  zero-extended magnitude estimate
module cplx_mag_est
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] mag
);

  localparam int H = WIDTH / 2;

  logic [H:0] re_x;
  logic [H:0] im_x;
  logic [H:0] abs_re;
  logic [H:0] abs_im;
  logic [H:0] hi;
  logic [H:0] lo;
  logic [H:0] sum;

  // Sign-extend each half by one bit, take absolute values, then max + min/2.
  always_comb begin
    re_x = {word[WIDTH-1], word[WIDTH-1:H]};
    im_x = {word[H-1], word[H-1:0]};
    if (re_x[H]) begin
      abs_re = (H+1)'(0) - re_x;
    end else begin
      abs_re = re_x;
    end
    if (im_x[H]) begin
      abs_im = (H+1)'(0) - im_x;
    end else begin
      abs_im = im_x;
    end
    if (abs_re >= abs_im) begin
      hi = abs_re;
      lo = abs_im;
    end else begin
      hi = abs_im;
      lo = abs_re;
    end
    // max <= 2^(H-1) and min/2 <= 2^(H-2), so the sum cannot overflow H+1 bits.
    sum = hi + (lo >> 1);
    mag = {{(WIDTH-H-1){1'b0}}, sum};
  end

endmodule

// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer
//   Snapshots the parallel FFT result array on load and streams the bins
//   out one per transfer over a valid/ready interface.
//   Optional feature macro: FFT_MAG_EN -- when defined, out_data carries the
//   magnitude estimate of each bin instead of the raw word.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              snapshot request, accepted only in IDLE
//   bins_in[SAMPLES]  result bins, bin k at [k]
//   out_valid/ready   stream handshake
//   out_data          bin word (or magnitude), out_index bin number,
//   out_last          final bin of frame
//   busy              frame held and not fully drained
//   done              one-cycle pulse after the final transfer
//   overrun           sticky: load seen while streaming
module fft_bin_streamer
  import fft_stream_pkg::*;
#(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [WIDTH-1:0]           bins_in [SAMPLES],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(SAMPLES)-1:0] out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int IW   = $clog2(SAMPLES);
  localparam int LAST = idx_last(SAMPLES);

  stream_state_t    state;
  logic [WIDTH-1:0] bin_buf [SAMPLES];
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    nxt_idx;
  logic             xfer;
  logic             last_beat;
  logic             accept;
  logic [WIDTH-1:0] src_word;
  logic [WIDTH-1:0] beat_word;

  // Next-beat selection: the word presented after this edge is either bin 0
  // of the incoming frame (on accept) or the following buffered bin.
  always_comb begin
    nxt_idx   = rd_idx + IW'(1);
    xfer      = (state == STREAM) && out_ready;
    last_beat = (rd_idx == IW'(LAST));
    accept    = (state == IDLE) && load;
    if (state == IDLE) begin
      src_word = bins_in[0];
    end else begin
      src_word = bin_buf[nxt_idx];
    end
  end

`ifdef FFT_MAG_EN
  cplx_mag_est #(
    .WIDTH (WIDTH)
  ) u_mag (
    .word (src_word),
    .mag  (beat_word)
  );
`else
  assign beat_word = src_word;
`endif

  // Snapshot buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < SAMPLES; k++) begin
        bin_buf[k] <= bins_in[k];
      end
    end
  end

  // Streamer FSM with registered stream outputs and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state     <= STREAM;
            rd_idx    <= '0;
            overrun   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_index <= '0;
            out_last  <= 1'b0;
            out_data  <= beat_word;
          end
        end
        STREAM: begin
          // Any load while streaming, including on the final transfer, is dropped.
          if (load) begin
            overrun <= 1'b1;
          end
          if (xfer) begin
            if (last_beat) begin
              state     <= IDLE;
              rd_idx    <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_index <= '0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
            end else begin
              rd_idx    <= nxt_idx;
              out_index <= nxt_idx;
              out_last  <= (nxt_idx == IW'(LAST));
              out_data  <= beat_word;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bin_streamer.sv
module tb_fft_bin_streamer;

  localparam int S  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [W-1:0]  bins_in [S];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overrun;

  fft_bin_streamer #(.SAMPLES(S), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bins_in   (bins_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame snapshot plus "which bin is on the wire".
  bit         m_stream;
  int         m_pos;
  logic [W-1:0] m_frame [S];
  bit         m_done;
  bit         m_ov;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] w);
`ifdef FFT_MAG_EN
    int re, im, hi, lo;
    re = $signed(w[31:16]);
    im = $signed(w[15:0]);
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    hi = (re > im) ? re : im;
    lo = (re > im) ? im : re;
    return W'(hi + lo / 2);
`else
    return w;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".valid"},   64'(out_valid), 64'(m_stream));
    check_val({tag, ".busy"},    64'(busy),      64'(m_stream));
    check_val({tag, ".done"},    64'(done),      64'(m_done));
    check_val({tag, ".overrun"}, 64'(overrun),   64'(m_ov));
    if (m_stream) begin
      check_val({tag, ".index"}, 64'(out_index), 64'(m_pos));
      check_val({tag, ".data"},  64'(out_data),  64'(ref_word(m_frame[m_pos])));
      check_val({tag, ".last"},  64'(out_last),  64'(m_pos == S - 1));
    end
  endtask

  // Apply inputs at a falling edge, advance the model, clock once, check.
  task automatic step(input bit ld, input bit rdy, input string tag);
    load      = ld;
    out_ready = rdy;
    m_done    = 1'b0;
    if (m_stream) begin
      if (ld) m_ov = 1'b1;
      if (rdy) begin
        if (m_pos == S - 1) begin
          m_stream = 1'b0;
          m_pos    = 0;
          m_done   = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end else if (ld) begin
      for (int k = 0; k < S; k++) m_frame[k] = bins_in[k];
      m_pos    = 0;
      m_stream = 1'b1;
      m_ov     = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_stream = 1'b0;
    m_pos    = 0;
    m_done   = 1'b0;
    m_ov     = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, ".valid"},   64'(out_valid), 64'd0);
    check_val({tag, ".data"},    64'(out_data),  64'd0);
    check_val({tag, ".index"},   64'(out_index), 64'd0);
    check_val({tag, ".last"},    64'(out_last),  64'd0);
    check_val({tag, ".busy"},    64'(busy),      64'd0);
    check_val({tag, ".done"},    64'(done),      64'd0);
    check_val({tag, ".overrun"}, 64'(overrun),   64'd0);
  endtask

  task automatic random_bins();
    for (int k = 0; k < S; k++) bins_in[k] = $urandom;
  endtask

  logic [W-1:0] t1_words [S];
  int           guard;

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < S; k++) bins_in[k] = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Test 1: straight drain of a known frame.
    t1_words[0] = 32'h00010002;
    t1_words[1] = 32'h00030004;
    t1_words[2] = 32'h00050006;
    t1_words[3] = 32'h00070008;
    for (int k = 0; k < S; k++) bins_in[k] = t1_words[k];
    step(1'b1, 1'b1, "t1.load");
    for (int k = 0; k < S; k++) begin
      check_val("t1.beat_idx", 64'(out_index), 64'(k));
`ifndef FFT_MAG_EN
      check_val("t1.beat_raw", 64'(out_data), 64'(t1_words[k]));
`endif
      random_bins();
      step(1'b0, 1'b1, "t1.beat");
    end
    check_val("t1.done_pulse", 64'(done), 64'd1);
    check_val("t1.busy_drop",  64'(busy), 64'd0);
    step(1'b0, 1'b0, "t1.after");

    // Test 2: ready toggling 1,0,0,1,... with stall stability via the model.
    random_bins();
    step(1'b1, 1'b0, "t2.load");
    guard = 0;
    while (m_stream && guard < 40) begin
      step(1'b0, (guard % 3) == 0, "t2.stall");
      guard++;
    end
    check_val("t2.drained", 64'(m_stream), 64'd0);
    step(1'b0, 1'b0, "t2.after");

    // Test 3: load while on beat 1 is ignored, sets sticky overrun.
    random_bins();
    step(1'b1, 1'b1, "t3.load");
    random_bins();
    step(1'b0, 1'b0, "t3.beat1");
    random_bins();
    step(1'b1, 1'b0, "t3.busy_load");
    check_val("t3.overrun_set", 64'(overrun), 64'd1);
    random_bins();
    while (m_stream) step(1'b0, 1'b1, "t3.drain");
    check_val("t3.overrun_sticky", 64'(overrun), 64'd1);
    random_bins();
    step(1'b1, 1'b1, "t3.reload");
    check_val("t3.overrun_clear", 64'(overrun), 64'd0);
    while (m_stream) step(1'b0, 1'b1, "t3.drain2");
    step(1'b0, 1'b0, "t3.after");

    // Test 4: asynchronous reset between edges while on beat 2.
    random_bins();
    step(1'b1, 1'b1, "t4.load");
    step(1'b0, 1'b1, "t4.b1");
    step(1'b0, 1'b0, "t4.b2");
    #2 rst = 1'b1;
    #1 check_reset_values("t4.async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, "t4.no_done");
    random_bins();
    step(1'b1, 1'b1, "t4.reload");
    check_val("t4.restart_idx", 64'(out_index), 64'd0);
    while (m_stream) step(1'b0, 1'b1, "t4.drain");
    step(1'b0, 1'b0, "t4.after");

`ifdef FFT_MAG_EN
    // Test 5: magnitude estimate corner values.
    bins_in[0] = 32'hFFFD0004;
    bins_in[1] = 32'h80000000;
    bins_in[2] = 32'h00000000;
    bins_in[3] = 32'h7FFF8000;
    step(1'b1, 1'b1, "t5.load");
    check_val("t5.mag_m3_4", 64'(out_data), 64'd5);
    step(1'b0, 1'b1, "t5.b1");
    check_val("t5.mag_min", 64'(out_data), 64'h8000);
    step(1'b0, 1'b1, "t5.b2");
    check_val("t5.mag_zero", 64'(out_data), 64'd0);
    while (m_stream) step(1'b0, 1'b1, "t5.drain");
    step(1'b0, 1'b0, "t5.after");
`endif

    // Test 6: load coincident with the final transfer.
    random_bins();
    step(1'b1, 1'b1, "t6.load");
    while (m_pos != S - 1) step(1'b0, 1'b1, "t6.run");
    random_bins();
    step(1'b1, 1'b1, "t6.final_load");
    check_val("t6.overrun", 64'(overrun),   64'd1);
    check_val("t6.idle",    64'(out_valid), 64'd0);
    check_val("t6.done",    64'(done),      64'd1);
    step(1'b0, 1'b0, "t6.done_once");

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      random_bins();
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
